// File: rtl/washer_pkg.sv
// rtl/washer_pkg.sv - shared washer constants, arbiter state encoding and temperature codes
// Contents:
//   wash_prog_e      washer program selection used by the machine controllers
//   arb_state_e      water inlet arbiter FSM states
//   TEMP_*           temperature codes, bit 1 = hot, bit 0 = cold
//   onehot_to_idx    index of the set bit in a one-hot vector of up to 8 bits

package washer_pkg;

   typedef enum logic [2:0] {
      PROG_COTTON   = 3'd0,
      PROG_SYNTH    = 3'd1,
      PROG_WOOL     = 3'd2,
      PROG_QUICK    = 3'd3,
      PROG_RINSE    = 3'd4
   } wash_prog_e;

   localparam logic [7:0] PROG_MAX_CYCLES = 8'd16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } arb_state_e;

   localparam logic [1:0] TEMP_COLD = 2'b01;
   localparam logic [1:0] TEMP_HOT  = 2'b10;
   localparam logic [1:0] TEMP_WARM = 2'b11;

   function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/water_inlet_arbiter_if.sv
// rtl/water_inlet_arbiter_if.sv - request/grant bundle between machine controllers and the inlet arbiter
// Signals:
//   req, req_cold, req_hot   per-requester fill request and temperature choice (both = warm)
//   grant                    one-hot inlet ownership
//   valve_in_cold/hot        physical valve drives
//   timeout                  one-cycle pulse when a grant is cut at the fill limit
//   fill_timer               cycles elapsed in the current grant
// Modports: master = controller side, slave = arbiter side.

interface water_inlet_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] req_cold;
   logic [N_REQ-1:0] req_hot;
   logic [N_REQ-1:0] grant;
   logic [N_REQ-1:0] timeout;
   logic             valve_in_cold;
   logic             valve_in_hot;
   logic [7:0]       fill_timer;

   modport master (
      output req, req_cold, req_hot,
      input  grant, timeout, valve_in_cold, valve_in_hot, fill_timer
   );

   modport slave (
      input  req, req_cold, req_hot,
      output grant, timeout, valve_in_cold, valve_in_hot, fill_timer
   );
endinterface

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin picker
// Ports:
//   elig_i   eligibility mask
//   last_i   index of the previous owner; the search starts just above it
//   sel_o    one-hot selected requester (0 when none eligible)
//   valid_o  a requester was selected

module rr_priority_pick #(
   parameter int N_REQ = 4,
   parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] elig_i,
   input  logic [IW-1:0]    last_i,
   output logic [N_REQ-1:0] sel_o,
   output logic             valid_o
);

   // Two passes instead of a modulo walk: indices above last_i first,
   // then wrap around to the indices at or below it.
   always_comb begin
      logic hit;
      hit   = 1'b0;
      sel_o = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!hit && (i > int'(last_i)) && elig_i[i]) begin
            sel_o[i] = 1'b1;
            hit      = 1'b1;
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!hit && (i <= int'(last_i)) && elig_i[i]) begin
            sel_o[i] = 1'b1;
            hit      = 1'b1;
         end
      end
   end

   assign valid_o = |sel_o;

endmodule

// File: rtl/water_inlet_arbiter.sv
// rtl/water_inlet_arbiter.sv - round-robin owner of the shared water inlet with fill limit and heater recovery
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   enable   mains power; low forces release and blocks new grants
//   bus      slave side of water_inlet_arbiter_if (requests in, grant/valves/timeout/fill_timer out)

module water_inlet_arbiter
   import washer_pkg::*;
#(
   parameter int         N_REQ        = 4,
   parameter logic [7:0] MAX_FILL     = 8'd40,
   parameter logic [7:0] HOT_RECOVERY = 8'd6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   water_inlet_arbiter_if.slave bus
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   arb_state_e       state_q;
   logic [N_REQ-1:0] grant_q;
   logic [N_REQ-1:0] timeout_q;
   logic [N_REQ-1:0] lockout_q, lockout_d;
   logic             valve_cold_q, valve_hot_q;
   logic             hot_lat_q;
   logic [7:0]       fill_q;
   logic [7:0]       recov_q, recov_d;
   logic [IW-1:0]    last_q;

   logic [N_REQ-1:0] elig;
   logic [N_REQ-1:0] pick_sel;
   logic             pick_valid;
   logic [1:0]       pick_temp;
   logic             hot_blocked;
   logic             owner_req;
   logic             arb_ok;
   logic             cut_now;

   // The recovery counter only loads as RELEASE is left, so during the
   // RELEASE cycle itself a hot grant that just ended must also block hot.
   assign hot_blocked = (recov_q != 8'd0) ||
                        ((state_q == ST_RELEASE) && hot_lat_q && (HOT_RECOVERY != 8'd0));

   assign elig = bus.req & (bus.req_cold | bus.req_hot) & ~lockout_q
               & ~(bus.req_hot & {N_REQ{hot_blocked}});

   rr_priority_pick #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_pick (
      .elig_i  (elig),
      .last_i  (last_q),
      .sel_o   (pick_sel),
      .valid_o (pick_valid)
   );

   assign pick_temp = {|(pick_sel & bus.req_hot), |(pick_sel & bus.req_cold)};
   assign owner_req = |(grant_q & bus.req);

   // Arbitration also runs in RELEASE so consecutive owners are separated
   // by exactly the one closed-valve cycle.
   assign arb_ok  = enable && pick_valid &&
                    ((state_q == ST_IDLE) || (state_q == ST_RELEASE));
   assign cut_now = (state_q == ST_GRANT) && enable && owner_req && (fill_q == MAX_FILL);

   // Lockout clears on any cycle the requester is seen low.
   assign lockout_d = (lockout_q & bus.req) | (cut_now ? grant_q : '0);

   always_comb begin
      recov_d = recov_q;
      if ((state_q == ST_RELEASE) && hot_lat_q) begin
         recov_d = HOT_RECOVERY;
      end else if (recov_q != 8'd0) begin
         recov_d = recov_q - 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         timeout_q    <= '0;
         lockout_q    <= '0;
         valve_cold_q <= 1'b0;
         valve_hot_q  <= 1'b0;
         hot_lat_q    <= 1'b0;
         fill_q       <= 8'd0;
         recov_q      <= 8'd0;
         last_q       <= IW'(N_REQ - 1);
      end else begin
         timeout_q <= '0;
         lockout_q <= lockout_d;
         recov_q   <= recov_d;
         case (state_q)
            ST_IDLE, ST_RELEASE: begin
               if (arb_ok) begin
                  state_q      <= ST_GRANT;
                  grant_q      <= pick_sel;
                  valve_cold_q <= pick_temp[0];
                  valve_hot_q  <= pick_temp[1];
                  hot_lat_q    <= (pick_temp == TEMP_HOT) || (pick_temp == TEMP_WARM);
                  fill_q       <= 8'd1;
                  last_q       <= IW'(onehot_to_idx(8'(pick_sel)));
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_GRANT: begin
               if (!enable || !owner_req || cut_now) begin
                  state_q      <= ST_RELEASE;
                  grant_q      <= '0;
                  valve_cold_q <= 1'b0;
                  valve_hot_q  <= 1'b0;
                  fill_q       <= 8'd0;
                  if (cut_now) timeout_q <= grant_q;
               end else begin
                  fill_q <= fill_q + 8'd1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.grant         = grant_q;
   assign bus.timeout       = timeout_q;
   assign bus.valve_in_cold = valve_cold_q;
   assign bus.valve_in_hot  = valve_hot_q;
   assign bus.fill_timer    = fill_q;

endmodule
